// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: clocked byte/half/word data memory that replaces the
// combinational byte array of the multi-cycle CPU. Big-endian lanes, a
// configurable wait-state count before ack, and a zero-fill sweep after reset.
// Optional macro DM_MISALIGN_EXC_EN adds the misalign port: misaligned
// requests then complete without touching memory and flag misalign with ack.
//
// Handshake: a request is accepted on the rising edge where req=1 and
// ready=1; all request fields are captured on that edge. Exactly one
// ack pulse follows WAIT_STATES+1 cycles later, and ready stays low from
// the accept edge until the cycle after ack.
module data_memory_ctrl #(
    parameter int DEPTH_BYTES = 64,
    parameter int WAIT_STATES = 0,
    parameter int CNT_W       = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] DAddr,
    input  logic [31:0] DataIn,
    output logic        ready,
    output logic        ack,
    output logic [31:0] DataOut,
    output logic        init_busy,
`ifdef DM_MISALIGN_EXC_EN
    output logic        misalign,
`endif
    output logic [1:0]  state_dbg
);

    localparam int AW     = $clog2(DEPTH_BYTES);
    localparam int NWORDS = DEPTH_BYTES / 4;
    localparam int WI_W   = (AW > 2) ? AW - 2 : 1;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [31:0]       mem [NWORDS];
    logic [WI_W-1:0]   init_idx;
    logic [CNT_W-1:0]  wcnt;

    // captured request
    logic              r_we, r_sx;
    logic [1:0]        r_size;
    logic [AW-1:0]     r_addr;
    logic [31:0]       r_din;

    // effective operation: live inputs on the accept edge, captured copy later
    logic              op_we, op_sx, op_mis, blocked, enter_resp, init_last;
    logic [1:0]        op_size;
    logic [AW-1:0]     op_addr;
    logic [31:0]       op_din, rd_word, ld_val, wdata;
    logic [WI_W-1:0]   widx;
    logic [3:0]        be;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;

    // Address bits above the memory size are ignored (address wraps).
    logic unused_addr_hi;
    assign unused_addr_hi = ^DAddr[31:AW];

`ifdef DM_MISALIGN_EXC_EN
    logic r_mis;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) state <= S_INIT;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_INIT: if (init_last) state_nx = S_IDLE;
            S_IDLE: if (req) state_nx = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (wcnt == '0) state_nx = S_RESP;
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_INIT;
        endcase
    end

    // Moore outputs decoded from the state
    always_comb begin
        ready     = (state == S_IDLE);
        ack       = (state == S_RESP);
        init_busy = (state == S_INIT);
        state_dbg = state;
`ifdef DM_MISALIGN_EXC_EN
        misalign  = (state == S_RESP) && r_mis;
`endif
    end

    // Select operation source, decode lanes and form load value
    always_comb begin
        init_last  = (init_idx == WI_W'(NWORDS - 1));
        enter_resp = (state_nx == S_RESP) && (state != S_RESP);
        if (state == S_IDLE) begin
            op_we   = we;
            op_size = size;
            op_sx   = sign_ext;
            op_addr = DAddr[AW-1:0];
            op_din  = DataIn;
        end else begin
            op_we   = r_we;
            op_size = r_size;
            op_sx   = r_sx;
            op_addr = r_addr;
            op_din  = r_din;
        end
        widx    = WI_W'(op_addr >> 2);
        op_mis  = ((op_size == 2'b01) && op_addr[0]) ||
                  (op_size[1] && (op_addr[1:0] != 2'b00));
`ifdef DM_MISALIGN_EXC_EN
        blocked = op_mis;
`else
        blocked = 1'b0;
`endif
        rd_word = mem[widx];
        case (op_addr[1:0])
            2'd0:    rd_byte = rd_word[31:24];
            2'd1:    rd_byte = rd_word[23:16];
            2'd2:    rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
        endcase
        // Half ignores A[0]; word ignores A[1:0] (silent alignment).
        rd_half = op_addr[1] ? rd_word[15:0] : rd_word[31:16];
        case (op_size)
            2'b00: begin
                ld_val = {{24{op_sx & rd_byte[7]}}, rd_byte};
                be     = 4'b1000 >> op_addr[1:0];
                wdata  = {4{op_din[7:0]}};
            end
            2'b01: begin
                ld_val = {{16{op_sx & rd_half[15]}}, rd_half};
                be     = op_addr[1] ? 4'b0011 : 4'b1100;
                wdata  = {2{op_din[15:0]}};
            end
            default: begin
                ld_val = rd_word;
                be     = 4'b1111;
                wdata  = op_din;
            end
        endcase
    end

    // Init sweep index, wait counter and request capture
    always_ff @(posedge CLK) begin
        if (Reset) begin
            init_idx <= '0;
            wcnt     <= '0;
            r_we     <= 1'b0;
            r_sx     <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= '0;
            r_din    <= '0;
`ifdef DM_MISALIGN_EXC_EN
            r_mis    <= 1'b0;
`endif
        end else begin
            if (state == S_INIT) init_idx <= init_idx + WI_W'(1);
            if (state == S_IDLE && req) begin
                r_we   <= we;
                r_sx   <= sign_ext;
                r_size <= size;
                r_addr <= DAddr[AW-1:0];
                r_din  <= DataIn;
                wcnt   <= (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
`ifdef DM_MISALIGN_EXC_EN
                r_mis  <= op_mis;
`endif
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - CNT_W'(1);
            end
        end
    end

    // Load result registered on the edge entering RESP; stores return zero
    always_ff @(posedge CLK) begin
        if (Reset)           DataOut <= '0;
        else if (enter_resp) DataOut <= (op_we || blocked) ? 32'h0 : ld_val;
    end

    // Memory array: zero sweep in INIT, byte-enabled store commit entering RESP
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            if (state == S_INIT) begin
                mem[init_idx] <= 32'h0;
            end else if (enter_resp && op_we && !blocked) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (WAIT_STATES=0 and 3) share the
// request inputs; a table of directed vectors plus hand-written reset/latency
// sequences, checked against hand-computed values.
module tb_data_memory_ctrl;

    logic        CLK, Reset, req, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] DAddr, DataIn;

    logic        rdy0, ack0, ib0, rdy1, ack1, ib1;
    logic [31:0] do0, do1;
    logic [1:0]  st0, st1;
`ifdef DM_MISALIGN_EXC_EN
    logic        mis0, mis1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        mis;
    } vec_t;

    vec_t vt[$];

    data_memory_ctrl #(.DEPTH_BYTES(64), .WAIT_STATES(0), .CNT_W(4)) u0 (
        .CLK(CLK), .Reset(Reset), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .DAddr(DAddr), .DataIn(DataIn),
        .ready(rdy0), .ack(ack0), .DataOut(do0), .init_busy(ib0),
`ifdef DM_MISALIGN_EXC_EN
        .misalign(mis0),
`endif
        .state_dbg(st0)
    );

    data_memory_ctrl #(.DEPTH_BYTES(64), .WAIT_STATES(3), .CNT_W(4)) u1 (
        .CLK(CLK), .Reset(Reset), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .DAddr(DAddr), .DataIn(DataIn),
        .ready(rdy1), .ack(ack1), .DataOut(do1), .init_busy(ib1),
`ifdef DM_MISALIGN_EXC_EN
        .misalign(mis1),
`endif
        .state_dbg(st1)
    );

    // clock / watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One request on the shared inputs; checks latency, data and spacing.
    task automatic do_op(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input logic emis);
        int  n = 0;
        bit  g0 = 0, g1 = 0, rdy_bad = 0;
        while (!(rdy0 && rdy1) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check({tag, " spacing"}, 32'(n), 32'd0);
        req = 1'b1; we = w; size = sz; sign_ext = sx; DAddr = a; DataIn = d;
        @(negedge CLK);
        req = 1'b0;
        we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
        DAddr = $urandom; DataIn = $urandom;
        for (int i = 1; i <= 20 && !(g0 && g1); i++) begin
            if (!g1 && rdy1) rdy_bad = 1;
            if (ack0 && !g0) begin
                g0 = 1;
                check({tag, " lat0"}, 32'(i), 32'd1);
                check({tag, " data0"}, do0, exp);
`ifdef DM_MISALIGN_EXC_EN
                check({tag, " mis0"}, {31'b0, mis0}, {31'b0, emis});
`endif
            end
            if (ack1 && !g1) begin
                g1 = 1;
                check({tag, " lat1"}, 32'(i), 32'd4);
                check({tag, " data1"}, do1, exp);
`ifdef DM_MISALIGN_EXC_EN
                check({tag, " mis1"}, {31'b0, mis1}, {31'b0, emis});
`endif
            end
            @(negedge CLK);
        end
        if (!g0) check({tag, " ack0 timeout"}, 32'd0, 32'd1);
        if (!g1) check({tag, " ack1 timeout"}, 32'd0, 32'd1);
        check({tag, " ready1 low"}, {31'b0, rdy_bad}, 32'd0);
    endtask

    // Counts init_busy cycles after Reset is released.
    task automatic wait_init(input string tag);
        int  n0 = 0, n1 = 0;
        bit  bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (ib0) n0++;
            if (ib1) n1++;
            if ((ib0 && rdy0) || (ib1 && rdy1)) bad = 1;
            if (!ib0 && !ib1) break;
            @(negedge CLK);
        end
        check({tag, " init len0"}, 32'(n0), 32'd16);
        check({tag, " init len1"}, 32'(n1), 32'd16);
        check({tag, " ready in init"}, {31'b0, bad}, 32'd0);
        check({tag, " ready after init"}, {30'b0, rdy1, rdy0}, 32'd3);
    endtask

    initial begin
        int  acks_seen;
        logic [31:0] e22, e24;
        logic        m22, m23;
`ifdef DM_MISALIGN_EXC_EN
        e22 = 32'h0;        m22 = 1'b1; m23 = 1'b1; e24 = 32'h11F03344;
`else
        e22 = 32'h000011F0; m22 = 1'b0; m23 = 1'b0; e24 = 32'hAAAA5555;
`endif
        //          w     sz    sx    addr   data          expected      mis
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h3C, 32'h0,        32'h00000000, 1'b0});
        vt.push_back('{1'b1, 2'd2, 1'b0, 32'h08, 32'h11223344, 32'h00000000, 1'b0});
        vt.push_back('{1'b0, 2'd0, 1'b0, 32'h08, 32'h0,        32'h00000011, 1'b0});
        vt.push_back('{1'b0, 2'd0, 1'b0, 32'h09, 32'h0,        32'h00000022, 1'b0});
        vt.push_back('{1'b0, 2'd0, 1'b0, 32'h0A, 32'h0,        32'h00000033, 1'b0});
        vt.push_back('{1'b0, 2'd0, 1'b0, 32'h0B, 32'h0,        32'h00000044, 1'b0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'h11223344, 1'b0});
        vt.push_back('{1'b1, 2'd0, 1'b0, 32'h09, 32'h123456F0, 32'h00000000, 1'b0});
        vt.push_back('{1'b0, 2'd0, 1'b1, 32'h09, 32'h0,        32'hFFFFFFF0, 1'b0});
        vt.push_back('{1'b0, 2'd1, 1'b0, 32'h08, 32'h0,        32'h000011F0, 1'b0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        32'h11F03344, 1'b0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h48, 32'h0,        32'h11F03344, 1'b0});
        vt.push_back('{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0,        32'h00003344, 1'b0});
        vt.push_back('{1'b1, 2'd1, 1'b0, 32'h0E, 32'hFFFF8001, 32'h00000000, 1'b0});
        vt.push_back('{1'b0, 2'd1, 1'b1, 32'h0E, 32'h0,        32'hFFFF8001, 1'b0});
        vt.push_back('{1'b0, 2'd1, 1'b0, 32'h0E, 32'h0,        32'h00008001, 1'b0});
        vt.push_back('{1'b0, 2'd0, 1'b1, 32'h0E, 32'h0,        32'hFFFFFF80, 1'b0});
        vt.push_back('{1'b0, 2'd0, 1'b1, 32'h0F, 32'h0,        32'h00000001, 1'b0});
        vt.push_back('{1'b0, 2'd3, 1'b0, 32'h0C, 32'h0,        32'h00008001, 1'b0});
        vt.push_back('{1'b1, 2'd0, 1'b0, 32'h3F, 32'h0000005A, 32'h00000000, 1'b0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,  32'h0000005A, 1'b0});
        vt.push_back('{1'b0, 2'd1, 1'b0, 32'h09, 32'h0,        e22,          m22});
        vt.push_back('{1'b1, 2'd2, 1'b0, 32'h0A, 32'hAAAA5555, 32'h00000000, m23});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        e24,          1'b0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0C, 32'h0,        32'h00008001, 1'b0});

        // reset block
        Reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
        DAddr = 32'h0; DataIn = 32'h0;
        repeat (2) @(negedge CLK);
        check("reset state", {30'b0, st0}, 32'd0);
        check("reset outs0", {29'b0, ib0, rdy0, ack0}, 32'b100);
        check("reset outs1", {29'b0, ib1, rdy1, ack1}, 32'b100);
        check("reset dataout", do0 | do1, 32'h0);
        Reset = 1'b0;
        wait_init("por");

        // table-driven vectors
        foreach (vt[k]) begin
            do_op($sformatf("vec%0d", k), vt[k].w, vt[k].sz, vt[k].sx,
                  vt[k].a, vt[k].d, vt[k].exp, vt[k].mis);
        end

        // Reset during the wait states of a store: no ack, memory re-cleared
        req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0;
        DAddr = 32'h10; DataIn = 32'hDEADBEEF;
        @(negedge CLK);
        req = 1'b0;
        check("mid-op in wait", {30'b0, st1}, 32'd2);
        Reset = 1'b1;
        @(negedge CLK);
        check("mid-op reset outs1", {29'b0, ib1, rdy1, ack1}, 32'b100);
        check("mid-op reset dataout1", do1, 32'h0);
        Reset = 1'b0;
        acks_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (ack1) acks_seen++;
            @(negedge CLK);
        end
        check("mid-op no ack", 32'(acks_seen), 32'd0);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        wait_init("mid-op");
        do_op("post-reset 0x10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        do_op("post-reset 0x08", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
